// File: rtl/tm_edge_ctx_pkg.sv
// Shared definitions for the TM neighbour-context generator: edge defaults,
// block lane indexing helpers and the control FSM encoding.
package tm_edge_ctx_pkg;

  localparam int BIT_WIDTH    = 8;
  localparam int BLOCK_SIZE   = 4;
  localparam int MAX_BLK_COLS = 64;
  localparam int COL_W        = 7;
  localparam int LINE_AW      = $clog2(MAX_BLK_COLS);

  // Substitute pixels when a neighbour lies outside the picture.
  localparam logic [BIT_WIDTH-1:0] TOP_DEFAULT  = 8'h7F;
  localparam logic [BIT_WIDTH-1:0] LEFT_DEFAULT = 8'h81;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OFFER,
    S_WAIT_REC,
    S_DONE
  } state_t;

  // Lane number of pixel (row, col) inside a raster-packed 4x4 block.
  function automatic int lane_idx(input int row, input int col);
    return row * BLOCK_SIZE + col;
  endfunction

  // Extract pixel (row, col) from a packed 4x4 block.
  function automatic logic [BIT_WIDTH-1:0] rec_px(
    input logic [BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0] blk,
    input int row, input int col);
    return blk[BIT_WIDTH*lane_idx(row, col) +: BIT_WIDTH];
  endfunction

endpackage

// File: rtl/tm_line_buf.sv
// Top line buffer: single-port RAM with registered read. A write cycle also
// reads, returning the value held before the write (read-first).
module tm_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic         we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [DEPTH];

  // Read-first port; contents are never reset, row 0 never reads them.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/tm_edge_ctx.sv
// Neighbour-context generator for 4x4 TrueMotion intra prediction. Walks the
// picture in block raster order, offers top/left/top_left for each block and
// takes the reconstructed block back before moving on.
module tm_edge_ctx
  import tm_edge_ctx_pkg::*;
#(
  parameter int BIT_WIDTH    = tm_edge_ctx_pkg::BIT_WIDTH,
  parameter int BLOCK_SIZE   = tm_edge_ctx_pkg::BLOCK_SIZE,
  parameter int MAX_BLK_COLS = tm_edge_ctx_pkg::MAX_BLK_COLS,
  parameter int COL_W        = tm_edge_ctx_pkg::COL_W
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [COL_W-1:0]                            blk_cols,
  input  logic [COL_W-1:0]                            blk_rows,
  output logic                                        ctx_valid,
  input  logic                                        ctx_ready,
  output logic [COL_W-1:0]                            ctx_x,
  output logic [COL_W-1:0]                            ctx_y,
  output logic [BIT_WIDTH-1:0]                        top_left,
  output logic [BLOCK_SIZE*BIT_WIDTH-1:0]             top,
  output logic [BLOCK_SIZE*BIT_WIDTH-1:0]             left,
  input  logic                                        rec_valid,
  output logic                                        rec_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0]  rec,
  output logic                                        busy,
  output logic                                        done
);

  localparam int ROW_W = BLOCK_SIZE * BIT_WIDTH;
  localparam int AW    = $clog2(MAX_BLK_COLS);
  localparam logic [COL_W-1:0] ONE     = COL_W'(1);
  localparam logic [COL_W-1:0] MAX_COL = COL_W'(MAX_BLK_COLS);

  state_t state, nxt;

  logic [COL_W-1:0] x, y, cols_s, rows_s;
  logic [ROW_W-1:0] left_reg, line_rd;
  logic [BIT_WIDTH-1:0] tl_reg;
  logic zero_done;
  logic rec_hs, last_col, last_blk, size_zero;
  logic [COL_W-1:0] cols_sat;
  logic [BLOCK_SIZE-1:0][BIT_WIDTH-1:0] rec_right;
  logic [ROW_W-1:0] rec_bottom;
  logic unused_rec;

  assign rec_hs    = (state == S_WAIT_REC) && rec_valid;
  assign last_col  = (x == cols_s - ONE);
  assign last_blk  = last_col && (y == rows_s - ONE);
  assign size_zero = (blk_cols == '0) || (blk_rows == '0);
  assign cols_sat  = (blk_cols > MAX_COL) ? MAX_COL : blk_cols;

  // Right column of the reconstructed block becomes the next block's left.
  for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_right
    assign rec_right[j] = rec_px(rec, j, BLOCK_SIZE - 1);
  end
  assign rec_bottom = rec[BLOCK_SIZE*ROW_W-1 -: ROW_W];
  assign unused_rec = ^rec;

  tm_line_buf #(.DEPTH(MAX_BLK_COLS), .AW(AW), .W(ROW_W)) u_line (
    .clk   (clk),
    .en    ((state == S_FETCH) || rec_hs),
    .we    (rec_hs),
    .addr  (x[AW-1:0]),
    .wdata (rec_bottom),
    .rdata (line_rd)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:     if (start && !size_zero) nxt = S_FETCH;
      S_FETCH:    nxt = S_OFFER;
      S_OFFER:    if (ctx_ready) nxt = S_WAIT_REC;
      S_WAIT_REC: if (rec_valid) nxt = last_blk ? S_DONE : S_FETCH;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Handshakes, status and edge-substituted context, driven only in OFFER.
  always_comb begin
    ctx_valid = (state == S_OFFER);
    rec_ready = (state == S_WAIT_REC);
    busy      = (state == S_FETCH) || (state == S_OFFER) || (state == S_WAIT_REC);
    done      = (state == S_DONE) || zero_done;
    ctx_x     = x;
    ctx_y     = y;
    top       = '0;
    left      = '0;
    top_left  = '0;
    if (state == S_OFFER) begin
      top      = (y == '0) ? {BLOCK_SIZE{TOP_DEFAULT}} : line_rd;
      left     = (x == '0) ? {BLOCK_SIZE{LEFT_DEFAULT}} : left_reg;
      top_left = (y == '0) ? TOP_DEFAULT :
                 (x == '0) ? LEFT_DEFAULT : tl_reg;
    end
  end

  // Sizes, block position and saved neighbour pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      cols_s    <= '0;
      rows_s    <= '0;
      left_reg  <= '0;
      tl_reg    <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      if (state == S_IDLE && start) begin
        zero_done <= size_zero;
        cols_s    <= cols_sat;
        rows_s    <= blk_rows;
        x         <= '0;
        y         <= '0;
      end
      if (rec_hs) begin
        left_reg <= rec_right;
        // Old bottom-right of the block above is the next block's corner.
        tl_reg   <= line_rd[ROW_W-1 -: BIT_WIDTH];
        if (last_blk) begin
          x <= '0;
          y <= '0;
        end else if (last_col) begin
          x <= '0;
          y <= y + ONE;
        end else begin
          x <= x + ONE;
        end
      end
    end
  end

endmodule

// File: doc/tm_edge_ctx.md
Name: tm_edge_ctx

Overview:
- Neighbour-context generator for the 4x4 TrueMotion intra prediction path.
- Holds reconstructed edge pixels (top line buffer, left column, top-left corner) and serves top/left/top_left for each 4x4 block in picture raster order.
- Consumes each reconstructed block back (clipped pred+residual) before offering the next block's context.
- Sits between the reconstruction stage and the TM predictor; it is the producer of the predictor's inputs.

Parameters:
BIT_WIDTH, 8, pixel width (lane logic fixed to 8-bit lanes)
BLOCK_SIZE, 4, block edge in pixels
MAX_BLK_COLS, 64, max picture width in 4x4 blocks; top line buffer depth
COL_W, 7, width of block-column/row counters and size inputs

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; sample sizes, begin picture (ignored unless idle)
blk_cols  in  COL_W  picture width in blocks
blk_rows  in  COL_W  picture height in blocks
ctx_valid  out  1  context for current block valid
ctx_ready  in  1  predictor accepts context
ctx_x  out  COL_W  current block column
ctx_y  out  COL_W  current block row
top_left  out  8  corner pixel
top  out  32  lane i = column i, bits [8i+7:8i]
left  out  32  lane j = row j
rec_valid  in  1  reconstructed block valid
rec_ready  out  1  high only in WAIT_REC
rec  in  128  lane (4j+i) = row j, column i
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse after last block stored

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, left/top_left registers 0. Line buffer contents are not reset; they are never read before being written, because edge defaults apply on row 0.
- FSM states:
  - IDLE: on start, sample sizes.
    - blk_cols or blk_rows = 0 -> done pulse next cycle, stay IDLE.
    - blk_cols > MAX_BLK_COLS -> saturate to MAX_BLK_COLS.
    - Otherwise x=y=0 and go to FETCH.
  - FETCH (1 cycle): synchronous read of line[x].
  - OFFER: ctx_valid=1, outputs stable until ctx_valid&ctx_ready, then go to WAIT_REC.
  - WAIT_REC: rec_ready=1. On handshake:
    - save old line[x] lane 3 into tl_next, then write line[x] <= rec[127:96] (bottom row);
    - left_reg <= {rec[127:120], rec[95:88], rec[63:56], rec[31:24]} (right column);
    - advance x; on wrap x=0, y++;
    - last block -> DONE, else FETCH.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Edge defaults:
  - y==0: top = 0x7F7F7F7F, top_left = 0x7F.
  - x==0: left = 0x81818181.
  - x==0 && y>0: top_left = 0x81.
  - Otherwise: top = line[x], left = left_reg, top_left = tl_reg (tl_next from the previous block).
- Latency: start at cycle 0 -> ctx_valid at cycle 2. rec handshake at cycle n -> next ctx_valid at n+2, or done at n+1 for the last block.
- blk_cols==1: write and read of line[0] fall in different cycles; no bypass needed.
- start while busy is ignored. rst mid-picture aborts: IDLE, no done.
- No arithmetic besides counters; counter compares use the sampled (saturated) sizes.

Decomposition:
- Shared package holds the edge constants TOP_DEFAULT=8'h7F and LEFT_DEFAULT=8'h81, the lane-index helpers, and the FSM state enum.
- One sub-module, tm_line_buf: single-port synchronous-read RAM, MAX_BLK_COLS x 32, with write-first disabled (read returns the old value).

Test Plan:
1. Reset, then start with cols=2, rows=1 -> block (0,0): top=0x7F7F7F7F, left=0x81818181, tl=0x7F, ctx_valid at cycle 2. Send rec with lanes 3/7/11/15 = 0x10,0x20,0x30,0x40 -> block (1,0): left=0x40302010, tl=0x7F; done after its rec.
2. cols=1, rows=2: rec0 bottom row 0x04030201 -> block (0,1): top=0x04030201, left=0x81818181, tl=0x81.
3. cols=2, rows=2: row-0 bottom rows 0x0A0B0C0D and 0x11223344 -> block (1,1): top=0x11223344, tl=0x0A.
4. Hold ctx_ready=0 for 5 cycles -> outputs stable, rec_ready stays 0. rec_valid asserted early is not accepted.
5. start with cols=0 -> done pulse in the next cycle, ctx_valid never asserted. cols=100 -> x wraps at 63.
6. rst asserted in WAIT_REC -> all outputs 0 immediately, no done. A new start then restarts cleanly at (0,0).
